// File: rtl/noc_ring_injector_pkg.sv
// Shared types for the ring NoC local-port injector: coordinates, message types,
// ring directions, flit preamble, header layout, FSM states and the direction helper.
package noc_ring_injector_pkg;

    localparam int xWidth           = 3;
    localparam int yWidth           = 3;
    localparam int xMax             = 8;
    localparam int yMax             = 8;
    localparam int nodeCount        = xMax * yMax;
    localparam int messageTypeWidth = 2;

    localparam int defaultFlitDataWidth = 32;
    localparam int defaultLenWidth      = 4;
    localparam int defaultCredits       = 4;

    typedef struct packed {
        logic [yWidth-1:0] y;
        logic [xWidth-1:0] x;
    } xy_t;

    typedef enum logic [messageTypeWidth-1:0] {
        MSG_READ  = 2'd0,
        MSG_WRITE = 2'd1,
        MSG_RESP  = 2'd2,
        MSG_INV   = 2'd3
    } message_t;

    typedef enum logic [2:0] {
        goEast  = 3'b001,
        goWest  = 3'b010,
        goLocal = 3'b100
    } direction_t;

    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    typedef struct packed {
        preamble_t                       pre;
        logic [defaultFlitDataWidth-1:0] data;
    } noc_flit_t;

    // Head flit payload, LSB first: dir | type | len | src | dest (zero padded above).
    typedef struct packed {
        xy_t                        dest;
        xy_t                        src;
        logic [defaultLenWidth-1:0] len;
        message_t                   mtype;
        direction_t                 dir;
    } head_info_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } inj_state_t;

    // Shortest way round the ring; an exact half-ring tie goes east.
    function automatic direction_t ring_direction(xy_t src, xy_t dst);
        int idx_src;
        int idx_dst;
        int fwd;
        idx_src = int'(src.y) * xMax + int'(src.x);
        idx_dst = int'(dst.y) * xMax + int'(dst.x);
        fwd     = (idx_dst + nodeCount - idx_src) % nodeCount;
        if (fwd == 0) begin
            return goLocal;
        end else if (fwd <= nodeCount / 2) begin
            return goEast;
        end else begin
            return goWest;
        end
    endfunction

endpackage

// File: rtl/noc_ring_injector_if.sv
// Handshake bundle between a message source, the injector and the router local port.
// slave is the injector's view, master the client/router side.
interface noc_ring_injector_if #(
    parameter int FlitDataWidth = noc_ring_injector_pkg::defaultFlitDataWidth,
    parameter int LenWidth      = noc_ring_injector_pkg::defaultLenWidth
);
    import noc_ring_injector_pkg::*;

    logic                     msg_valid;
    logic                     msg_ready;
    xy_t                      msg_dest;
    message_t                 msg_type;
    logic [LenWidth-1:0]      msg_len;
    logic                     pl_valid;
    logic                     pl_ready;
    logic [FlitDataWidth-1:0] pl_data;
    logic                     flit_valid;
    logic [FlitDataWidth+1:0] flit_data;
    logic                     credit_in;

    modport master (
        output msg_valid, msg_dest, msg_type, msg_len, pl_valid, pl_data, credit_in,
        input  msg_ready, pl_ready, flit_valid, flit_data
    );

    modport slave (
        input  msg_valid, msg_dest, msg_type, msg_len, pl_valid, pl_data, credit_in,
        output msg_ready, pl_ready, flit_valid, flit_data
    );

endinterface

// File: rtl/noc_ring_injector_credit_counter.sv
// Credit counter toward the router local input buffer. Starts full, drops on each
// send, rises on each returned credit, saturates at Credits (a protocol error).
module noc_credit_counter #(
    parameter int Credits = 4,
    localparam int CountWidth = $clog2(Credits + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  consume,
    input  logic                  credit_in,
    output logic                  avail,
    output logic [CountWidth-1:0] count
);

    assign avail = (count != '0);

    // Credit bookkeeping; a send and a return in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CountWidth'(Credits);
        end else if (consume && !credit_in) begin
            count <= count - CountWidth'(1);
        end else if (credit_in && !consume && (count != CountWidth'(Credits))) begin
            count <= count + CountWidth'(1);
        end
    end

    credit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(credit_in && !consume && (count == CountWidth'(Credits))));

endmodule

// File: rtl/noc_ring_injector.sv
// Local-port injection stage: packs a message request plus streamed payload into
// head/body/tail flits for the ring router, with credit-based flow control.
// Optional NOC_INJECT_STATS_EN adds wrapping packet/flit counters stat_pkts/stat_flits.
// FlitDataWidth must be >= 2*(xWidth+yWidth)+messageTypeWidth+LenWidth+3.
module noc_ring_injector
    import noc_ring_injector_pkg::*;
#(
    parameter int FlitDataWidth = defaultFlitDataWidth,
    parameter int LenWidth      = defaultLenWidth,
    parameter int Credits       = defaultCredits
) (
    input  logic                    clk,
    input  logic                    rst,
    input  xy_t                     local_xy,
    noc_ring_injector_if.slave      bus,
    output logic                    busy
`ifdef NOC_INJECT_STATS_EN
    ,
    output logic [31:0]             stat_pkts,
    output logic [31:0]             stat_flits
`endif
);

    localparam int CountWidth = $clog2(Credits + 1);

    inj_state_t               state;
    inj_state_t               state_next;
    logic                     msg_ready;
    logic                     pl_ready;
    logic                     msg_accept;
    logic                     send_head;
    logic                     send_body;
    logic                     credit_avail;
    logic [CountWidth-1:0]    credit_count;

    xy_t                      hdr_dest;
    message_t                 hdr_type;
    logic [LenWidth-1:0]      hdr_len;
    direction_t               hdr_dir;
    logic [LenWidth-1:0]      rem;

    preamble_t                flit_pre_next;
    logic [FlitDataWidth-1:0] flit_payload_next;
    logic                     flit_valid_q;
    logic [FlitDataWidth+1:0] flit_data_q;

    assign msg_accept     = msg_ready && bus.msg_valid;
    assign bus.msg_ready  = msg_ready;
    assign bus.pl_ready   = pl_ready;
    assign bus.flit_valid = flit_valid_q;
    assign bus.flit_data  = flit_data_q;
    assign busy           = (state != IDLE);

    noc_credit_counter #(
        .Credits (Credits)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .consume   (send_head || send_body),
        .credit_in (bus.credit_in),
        .avail     (credit_avail),
        .count     (credit_count)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake readies and send decisions.
    always_comb begin
        state_next = state;
        msg_ready  = 1'b0;
        pl_ready   = 1'b0;
        send_head  = 1'b0;
        send_body  = 1'b0;
        unique case (state)
            IDLE: begin
                msg_ready = !rst;
                if (bus.msg_valid && !rst) begin
                    state_next = HEAD;
                end
            end
            HEAD: begin
                if (credit_avail) begin
                    send_head  = 1'b1;
                    state_next = (hdr_len == '0) ? IDLE : BODY;
                end
            end
            BODY: begin
                pl_ready = credit_avail;
                if (bus.pl_valid && credit_avail) begin
                    send_body = 1'b1;
                    if (rem == LenWidth'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Header latch on accept, and the remaining-body-flit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_dest <= '0;
            hdr_type <= MSG_READ;
            hdr_len  <= '0;
            hdr_dir  <= goLocal;
            rem      <= '0;
        end else begin
            if (msg_accept) begin
                hdr_dest <= bus.msg_dest;
                hdr_type <= bus.msg_type;
                hdr_len  <= bus.msg_len;
                hdr_dir  <= ring_direction(local_xy, bus.msg_dest);
            end
            if (send_head) begin
                rem <= hdr_len;
            end else if (send_body) begin
                rem <= rem - LenWidth'(1);
            end
        end
    end

    // Assemble the flit decided this cycle.
    always_comb begin
        flit_pre_next     = '0;
        flit_payload_next = '0;
        if (send_head) begin
            flit_pre_next.head = 1'b1;
            flit_pre_next.tail = (hdr_len == '0);
            flit_payload_next  = FlitDataWidth'({hdr_dest, local_xy, hdr_len, hdr_type, hdr_dir});
        end else if (send_body) begin
            flit_pre_next.tail = (rem == LenWidth'(1));
            flit_payload_next  = bus.pl_data;
        end
    end

    // Output register toward the router: decision in cycle t shows up in t+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_valid_q <= 1'b0;
            flit_data_q  <= '0;
        end else begin
            flit_valid_q <= send_head || send_body;
            if (send_head || send_body) begin
                flit_data_q <= {flit_pre_next, flit_payload_next};
            end
        end
    end

`ifdef NOC_INJECT_STATS_EN
    // Wrapping packet and flit counters, counted at the send decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts  <= '0;
            stat_flits <= '0;
        end else begin
            if (send_head) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (send_head || send_body) begin
                stat_flits <= stat_flits + 32'd1;
            end
        end
    end
`endif

    no_send_without_credit: assert property (@(posedge clk) disable iff (rst)
        (send_head || send_body) |-> (credit_count != '0));

endmodule
